// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared opcode, flag index and flag struct definitions for alu_pipe
package alu_pipe_pkg;

    // ADD/SUB/AND/OR keep the legacy 2-bit encodings zero-extended.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_ADC = 3'b101,
        OP_SBC = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle between operand fetch, alu_pipe and writeback
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    import alu_pipe_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_t          op;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [3:0]       flags_q;

    modport master (
        output in_valid, a, b, op, set_flags, out_ready,
        input  in_ready, out_valid, result, flags, flags_q
    );

    modport slave (
        input  in_valid, a, b, op, set_flags, out_ready,
        output in_ready, out_valid, result, flags, flags_q
    );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational WIDTH-bit ALU producing result and NZCV flags
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    input  logic             cin,
    input  flags_t           flags_in,
    output logic [WIDTH-1:0] res,
    output flags_t           flags_out
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] arith_res;
    logic             sub_op;
    logic             logic_op;
    logic             ci;
    logic             slt;
    logic [3:0]       fv;
    logic             unused_nz;

    assign unused_nz = flags_in.n ^ flags_in.z;

    always_comb begin
        ci        = (op == OP_ADC || op == OP_SBC) ? cin : 1'b0;
        sub_op    = (op == OP_SUB || op == OP_SBC || op == OP_SLT);
        logic_op  = (op == OP_AND || op == OP_OR || op == OP_XOR);
        // Zero-extended operands: bit WIDTH is carry for add and borrow for subtract.
        if (sub_op)
            ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};
        else
            ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        arith_res = ext[MSB:0];
        slt       = $signed(a) < $signed(b);

        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
            default: res = arith_res;
        endcase

        fv = '0;
        if (logic_op) begin
            fv[FLAG_N] = res[MSB];
            fv[FLAG_Z] = (res == '0);
            fv[FLAG_C] = flags_in.c;
            fv[FLAG_V] = flags_in.v;
        end else begin
            // SLT reports the flags of the underlying subtraction, not of its 0/1 result.
            fv[FLAG_N] = arith_res[MSB];
            fv[FLAG_Z] = (arith_res == '0);
            fv[FLAG_C] = ext[WIDTH];
            if (sub_op)
                fv[FLAG_V] = (a[MSB] != b[MSB]) && (arith_res[MSB] != a[MSB]);
            else
                fv[FLAG_V] = (a[MSB] == b[MSB]) && (arith_res[MSB] != a[MSB]);
        end
        flags_out = fv;
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined ALU: one-deep valid/ready result stage plus architectural NZCV register
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);

    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;
    logic [WIDTH-1:0] result_r;
    flags_t           flags_r;
    flags_t           flags_q_r;
    logic             out_valid_r;
    logic             acc;

    // Ready whenever the output slot is empty or draining this cycle.
    assign bus.in_ready = !out_valid_r | bus.out_ready;
    assign acc          = bus.in_valid & bus.in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (bus.a),
        .b         (bus.b),
        .op        (bus.op),
        .cin       (flags_q_r.c),
        .flags_in  (flags_q_r),
        .res       (core_res),
        .flags_out (core_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            flags_r     <= '0;
            flags_q_r   <= '0;
        end else if (acc) begin
            out_valid_r <= 1'b1;
            result_r    <= core_res;
            flags_r     <= core_flags;
            if (bus.set_flags)
                flags_q_r <= core_flags;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;
    assign bus.flags_q   = flags_q_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe at WIDTH=8 and WIDTH=32
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, out_ready, set_flags;
    logic [2:0]  op;
    logic [31:0] a32, b32;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8))  bus8  ();
    alu_pipe_if #(.WIDTH(32)) bus32 ();

    alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    assign bus8.in_valid   = in_valid;
    assign bus8.out_ready  = out_ready;
    assign bus8.set_flags  = set_flags;
    assign bus8.op         = alu_op_t'(op);
    assign bus8.a          = a32[7:0];
    assign bus8.b          = b32[7:0];
    assign bus32.in_valid  = in_valid;
    assign bus32.out_ready = out_ready;
    assign bus32.set_flags = set_flags;
    assign bus32.op        = alu_op_t'(op);
    assign bus32.a         = a32;
    assign bus32.b         = b32;

    logic [63:0] o_res   [2];
    logic [3:0]  o_fl    [2];
    logic [3:0]  o_fq    [2];
    logic        o_valid [2];
    logic        o_ready [2];

    assign o_res[0]   = 64'(bus8.result);
    assign o_res[1]   = 64'(bus32.result);
    assign o_fl[0]    = bus8.flags;
    assign o_fl[1]    = bus32.flags;
    assign o_fq[0]    = bus8.flags_q;
    assign o_fq[1]    = bus32.flags_q;
    assign o_valid[0] = bus8.out_valid;
    assign o_valid[1] = bus32.out_valid;
    assign o_ready[0] = bus8.in_ready;
    assign o_ready[1] = bus32.in_ready;

    // Reference state: a one-slot result buffer and the architectural flags, per width.
    int          wd     [2] = '{8, 32};
    logic        pend_v [2];
    logic [63:0] pend_r [2];
    logic [3:0]  pend_f [2];
    logic [3:0]  fq_m   [2];
    int          n_acc  [2];
    int          n_dlv  [2];
    bit          live;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Result and {N,Z,C,V} from signed/unsigned integer arithmetic on the operand values.
    function automatic logic [67:0] ref_alu(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] o, input logic [3:0] fq);
        longint unsigned mask, ci;
        longint          sa, sb, smax, smin, sres;
        logic [63:0]     r;
        logic            n, z, c, v;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
        smax = (longint'(1) <<< (w-1)) - 1;
        smin = -smax - 1;
        ci   = (o == 3'd5 || o == 3'd6) ? longint'(fq[1]) : 64'd0;
        c    = fq[1];
        v    = fq[0];
        r    = '0;
        case (o)
            3'd0, 3'd5: begin
                r    = (a + b + ci) & mask;
                c    = (a + b + ci) > mask;
                sres = sa + sb + longint'(ci);
                v    = (sres > smax) || (sres < smin);
            end
            3'd1, 3'd6, 3'd7: begin
                r    = (a - b - ci) & mask;
                c    = a < (b + ci);
                sres = sa - sb - longint'(ci);
                v    = (sres > smax) || (sres < smin);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: r = a ^ b;
        endcase
        n = r[w-1];
        z = (r == 64'd0);
        if (o == 3'd7)
            r = (sa < sb) ? 64'd1 : 64'd0;
        return {r, n, z, c, v};
    endfunction

    task automatic tick();
        logic [67:0] r;
        logic        acc;
        logic [63:0] am, bm;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (live) begin
                check($sformatf("w%0d in_ready", wd[i]), 64'(o_ready[i]), 64'(!pend_v[i] | out_ready));
                check($sformatf("w%0d out_valid", wd[i]), 64'(o_valid[i]), 64'(pend_v[i]));
                if (pend_v[i]) begin
                    check($sformatf("w%0d result", wd[i]), o_res[i], pend_r[i]);
                    check($sformatf("w%0d flags", wd[i]), 64'(o_fl[i]), 64'(pend_f[i]));
                end
                check($sformatf("w%0d flags_q", wd[i]), 64'(o_fq[i]), 64'(fq_m[i]));
            end
            if (rst) begin
                pend_v[i] = 1'b0;
                fq_m[i]   = 4'd0;
                n_acc[i]  = n_dlv[i];
            end else begin
                acc = in_valid & (!pend_v[i] | out_ready);
                if (pend_v[i] && out_ready) begin
                    pend_v[i] = 1'b0;
                    n_dlv[i]++;
                end
                if (acc) begin
                    am = (i == 0) ? 64'(a32[7:0]) : 64'(a32);
                    bm = (i == 0) ? 64'(b32[7:0]) : 64'(b32);
                    r  = ref_alu(wd[i], am, bm, op, fq_m[i]);
                    pend_v[i] = 1'b1;
                    pend_r[i] = r[67:4];
                    pend_f[i] = r[3:0];
                    if (set_flags)
                        fq_m[i] = r[3:0];
                    n_acc[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic sf);
        in_valid  = 1'b1;
        op        = o;
        a32       = x;
        b32       = y;
        set_flags = sf;
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0080;
            5: return 32'hFFFF_FF7F;
            6: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; set_flags = 1'b0; op = 3'd0; a32 = '0; b32 = '0;
        live = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0; pend_r[i] = '0; pend_f[i] = '0; fq_m[i] = '0;
            n_acc[i] = 0; n_dlv[i] = 0;
        end
        rst = 1'b1;
        tick();
        live = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst out_valid", 64'(o_valid[1]), 64'd0);
        check("rst result", o_res[1], 64'd0);
        check("rst flags", 64'(o_fl[1]), 64'd0);
        check("rst flags_q", 64'(o_fq[1]), 64'd0);
        check("rst in_ready", 64'(o_ready[1]), 64'd1);
        out_ready = 1'b1;

        beat(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check("add wrap valid", 64'(o_valid[1]), 64'd1);
        check("add wrap result", o_res[1], 64'd0);
        check("add wrap flags", 64'(o_fl[1]), 64'b0110);
        check("add wrap flags_q", 64'(o_fq[1]), 64'b0110);

        beat(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
        check("add ovf result", o_res[1], 64'h8000_0000);
        check("add ovf flags", 64'(o_fl[1]), 64'b1001);
        beat(3'd5, 32'h0, 32'h0, 1'b1);
        check("adc cin0 result", o_res[1], 64'd0);
        check("adc cin0 flags", 64'(o_fl[1]), 64'b0100);

        beat(3'd1, 32'h0, 32'h1, 1'b1);
        check("sub borrow result", o_res[1], 64'hFFFF_FFFF);
        check("sub borrow flags", 64'(o_fl[1]), 64'b1010);
        beat(3'd6, 32'h5, 32'h2, 1'b1);
        check("sbc cin1 result", o_res[1], 64'd2);

        beat(3'd0, 32'h10, 32'h20, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat(3'd3, 32'h100 + 32'(k), 32'h5 * 32'(k), 1'b1);
            check("stall in_ready", 64'(o_ready[1]), 64'd0);
            check("stall result", o_res[1], 64'h30);
            check("stall flags", 64'(o_fl[1]), 64'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            beat(3'd4, 32'hA5A5_0000 + 32'(k), 32'h0F0F_0F0F, 1'b0);
        check("drain last result", o_res[1], 64'hAAAA_0F0D);

        beat(3'd7, 32'hFFFF_FFFE, 32'h1, 1'b0);
        check("slt result", o_res[1], 64'd1);
        check("slt flags", 64'(o_fl[1]), 64'b1000);
        beat(3'd1, 32'h0, 32'h1, 1'b1);
        beat(3'd2, 32'hF0, 32'h0F, 1'b1);
        check("and keeps C result", o_res[1], 64'd0);
        check("and keeps C flags", 64'(o_fl[1]), 64'b0110);
        check("and keeps C flags_q", 64'(o_fq[1]), 64'b0110);
        in_valid = 1'b0;
        tick();

        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            set_flags = 1'($urandom);
            a32       = pick();
            b32       = pick();
            rst       = (c == 500);
            tick();
            if (c == 500) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("w%0d midrst out_valid", wd[i]), 64'(o_valid[i]), 64'd0);
                    check($sformatf("w%0d midrst flags_q", wd[i]), 64'(o_fq[i]), 64'd0);
                end
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 2; i++)
            check($sformatf("w%0d beats delivered", wd[i]), 64'(n_dlv[i]), 64'(n_acc[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
